// File: rtl/led_blink_pkg.sv
// Shared types and widths for the LED blink driver and its interval timer.
package led_blink_pkg;

   localparam int unsigned PEND_W = 4;
   localparam int unsigned CNT_W  = 32;

   typedef enum logic [1:0] {
      IDLE,
      ON,
      OFF
   } state_e;

endpackage

// File: rtl/led_interval_timer.sv
// Free-running interval counter; done marks the last cycle of a limit-long interval.
module led_interval_timer
   import led_blink_pkg::*;
(
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             enable,
   input  logic [CNT_W-1:0] limit,
   output logic             done
);

   logic [CNT_W-1:0] cnt_q;

   // clear wins over enable so the terminal cycle restarts the next interval at zero
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (enable) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign done = enable && (cnt_q == (limit - CNT_W'(1)));

endmodule

// File: rtl/led_blink_driver.sv
// Turns single-cycle events into distinct fixed-length LED blinks, queueing events that
// arrive mid-blink up to PENDING_MAX and flagging any that are dropped.
module led_blink_driver
   import led_blink_pkg::*;
#(
   parameter int unsigned ON_TIME     = 32'd0_500_000,
   parameter int unsigned OFF_TIME    = 32'd0_500_000,
   parameter int unsigned PENDING_MAX = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              event_pulse,
   output logic              led,
   output logic              busy,
   output logic [PEND_W-1:0] pending,
   output logic              overflow
);

   localparam logic [PEND_W-1:0] PendMax = PEND_W'(PENDING_MAX);

   state_e            state_q, state_d;
   logic [PEND_W-1:0] pend_d;
   logic              ovf_d;
   logic              consume;
   logic              t_clear;
   logic              t_enable;
   logic              t_done;
   logic [CNT_W-1:0]  t_limit;

   led_interval_timer u_timer (
      .clk    (clk),
      .rst    (rst),
      .clear  (t_clear),
      .enable (t_enable),
      .limit  (t_limit),
      .done   (t_done)
   );

   always_comb begin
      state_d  = state_q;
      t_clear  = 1'b0;
      t_enable = 1'b0;
      consume  = 1'b0;
      t_limit  = (state_q == ON) ? CNT_W'(ON_TIME) : CNT_W'(OFF_TIME);

      unique case (state_q)
         IDLE: begin
            t_clear = 1'b1;
            if (event_pulse) begin
               state_d = ON;
            end
         end
         ON: begin
            t_enable = 1'b1;
            if (t_done) begin
               t_clear = 1'b1;
               state_d = OFF;
            end
         end
         OFF: begin
            t_enable = 1'b1;
            if (t_done) begin
               t_clear = 1'b1;
               if (pending != '0) begin
                  state_d = ON;
                  consume = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         default: begin
            t_clear = 1'b1;
            state_d = IDLE;
         end
      endcase
   end

   // An event while idle starts a blink directly; only mid-blink events are queued.
   always_comb begin
      pend_d = pending;
      ovf_d  = 1'b0;
      if (event_pulse && (state_q != IDLE)) begin
         if (!consume) begin
            if (pending == PendMax) begin
               ovf_d = 1'b1;
            end else begin
               pend_d = pending + PEND_W'(1);
            end
         end
      end else if (consume) begin
         pend_d = pending - PEND_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         led      <= 1'b0;
         busy     <= 1'b0;
         pending  <= '0;
         overflow <= 1'b0;
      end else begin
         state_q  <= state_d;
         led      <= (state_d == ON);
         busy     <= (state_d != IDLE);
         pending  <= pend_d;
         overflow <= ovf_d;
      end
   end

endmodule

// File: tb/tb_led_blink_driver.sv
// Bench for led_blink_driver: directed scenarios with literal expectations plus random
// traffic checked every cycle against an elapsed-time model of the blink sequence.
module tb_led_blink_driver;

   localparam int ON   = 4;
   localparam int OFF  = 3;
   localparam int PMAX = 3;
   localparam int PER  = ON + OFF;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       event_pulse = 1'b0;
   logic       led, busy, overflow;
   logic [3:0] pending;

   int n_cmp = 0;
   int n_bad = 0;

   led_blink_driver #(
      .ON_TIME     (ON),
      .OFF_TIME    (OFF),
      .PENDING_MAX (PMAX)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .event_pulse (event_pulse),
      .led         (led),
      .busy        (busy),
      .pending     (pending),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
      end
   endtask

   // Model: position within the current blink period (-1 = idle) and queued event count.
   int m_pos = -1, m_q = 0, m_pos_d, m_q_d;
   bit m_ovf = 1'b0, m_ovf_d, m_end, m_cons;
   bit m_valid = 1'b0;

   always_comb begin
      m_end   = (m_pos == PER - 1);
      m_cons  = m_end && (m_q > 0);
      m_pos_d = -1;
      m_q_d   = m_q;
      m_ovf_d = 1'b0;
      if (m_pos < 0) m_pos_d = event_pulse ? 0 : -1;
      else if (m_end) m_pos_d = (m_q > 0) ? 0 : -1;
      else m_pos_d = m_pos + 1;
      if (m_pos >= 0 && event_pulse) begin
         if (!m_cons) begin
            if (m_q == PMAX) m_ovf_d = 1'b1;
            else m_q_d = m_q + 1;
         end
      end else if (m_cons) begin
         m_q_d = m_q - 1;
      end
      if (rst) begin
         m_pos_d = -1;
         m_q_d   = 0;
         m_ovf_d = 1'b0;
      end
   end

   always @(posedge clk) begin
      m_pos <= m_pos_d;
      m_q   <= m_q_d;
      m_ovf <= m_ovf_d;
      if (rst) m_valid <= 1'b1;
   end

   always @(negedge clk) begin
      if (m_valid) begin
         check("led", int'(led), int'(m_pos >= 0 && m_pos < ON));
         check("busy", int'(busy), int'(m_pos >= 0));
         check("pending", int'(pending), m_q);
         check("overflow", int'(overflow), int'(m_ovf));
      end
   end

   logic       led_a[64];
   logic       busy_a[64];
   logic       ovf_a[64];
   logic [3:0] pend_a[64];

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Cycle 0 is the first cycle after a two-cycle reset; outputs are recorded per cycle.
   task automatic run_scn(input logic [63:0] evm, input logic [63:0] rsm, input int n);
      rst = 1'b1;
      event_pulse = 1'b0;
      step();
      step();
      for (int c = 0; c < n; c++) begin
         step();
         led_a[c]  = led;
         busy_a[c] = busy;
         ovf_a[c]  = overflow;
         pend_a[c] = pending;
         rst = rsm[c];
         event_pulse = evm[c];
      end
      rst = 1'b0;
      event_pulse = 1'b0;
   endtask

   function automatic int rises(input int n);
      int r = 0;
      for (int i = 1; i < n; i++) if (led_a[i] && !led_a[i-1]) r++;
      return r;
   endfunction

   function automatic int ovf_count(input int n);
      int r = 0;
      for (int i = 0; i < n; i++) if (ovf_a[i]) r++;
      return r;
   endfunction

   int dens;
   int dl[4] = '{5, 20, 50, 90};

   initial begin
      // Single event
      run_scn(64'd1 << 10, 64'd0, 40);
      check("rst_led", int'(led_a[0]), 0);
      check("rst_busy", int'(busy_a[0]), 0);
      check("rst_pending", int'(pend_a[0]), 0);
      check("rst_overflow", int'(ovf_a[0]), 0);
      check("single_led10", int'(led_a[10]), 0);
      check("single_led11", int'(led_a[11]), 1);
      check("single_led14", int'(led_a[14]), 1);
      check("single_led15", int'(led_a[15]), 0);
      check("single_busy17", int'(busy_a[17]), 1);
      check("single_busy18", int'(busy_a[18]), 0);
      check("single_blinks", rises(40), 1);

      // Three events, two queued
      run_scn((64'd1 << 10) | (64'd1 << 12) | (64'd1 << 13), 64'd0, 40);
      check("three_pend13", int'(pend_a[13]), 1);
      check("three_pend14", int'(pend_a[14]), 2);
      check("three_led17", int'(led_a[17]), 0);
      check("three_led18", int'(led_a[18]), 1);
      check("three_pend18", int'(pend_a[18]), 1);
      check("three_led21", int'(led_a[21]), 1);
      check("three_led22", int'(led_a[22]), 0);
      check("three_led25", int'(led_a[25]), 1);
      check("three_pend25", int'(pend_a[25]), 0);
      check("three_led28", int'(led_a[28]), 1);
      check("three_led29", int'(led_a[29]), 0);
      check("three_blinks", rises(40), 3);

      // Saturation: five back-to-back events
      run_scn(64'h1F << 11, 64'd0, 50);
      check("sat_pend15", int'(pend_a[15]), 3);
      check("sat_ovf16", int'(ovf_a[16]), 1);
      check("sat_ovf_count", ovf_count(50), 1);
      check("sat_pend16", int'(pend_a[16]), 3);
      check("sat_blinks", rises(50), 4);

      // Event coincident with the OFF->ON consume
      run_scn((64'd1 << 10) | (64'd1 << 12) | (64'd1 << 17), 64'd0, 40);
      check("coin_pend17", int'(pend_a[17]), 1);
      check("coin_pend18", int'(pend_a[18]), 1);
      check("coin_led25", int'(led_a[25]), 1);
      check("coin_blinks", rises(40), 3);

      // Reset mid-ON with two queued
      run_scn((64'd1 << 10) | (64'd1 << 12) | (64'd1 << 13), 64'd1 << 14, 40);
      check("abort_pend14", int'(pend_a[14]), 2);
      check("abort_led15", int'(led_a[15]), 0);
      check("abort_busy15", int'(busy_a[15]), 0);
      check("abort_pend15", int'(pend_a[15]), 0);
      check("abort_blinks", rises(40), 1);

      // Reset and event together, then an event after reset falls
      run_scn((64'd1 << 5) | (64'd1 << 7), 64'h7 << 3, 20);
      check("rstev_busy6", int'(busy_a[6]), 0);
      check("rstev_busy7", int'(busy_a[7]), 0);
      check("rstev_led8", int'(led_a[8]), 1);
      check("rstev_led11", int'(led_a[11]), 1);
      check("rstev_blinks", rises(20), 1);

      // Random traffic against the model
      dens = dl[0];
      for (int i = 0; i < 4000; i++) begin
         step();
         if (i % 500 == 0) dens = dl[$urandom_range(0, 3)];
         rst = ($urandom_range(0, 299) == 0);
         event_pulse = ($urandom_range(0, 99) < dens);
      end
      rst = 1'b0;
      event_pulse = 1'b0;
      for (int i = 0; i < 40; i++) step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/led_blink_driver.md
LED_BLINK_DRIVER -- requirements
Module: led_blink_driver

Interface
REQ-001 SHALL have parameter ON_TIME, default 32'd0_500_000, LED-on duration per event in clk cycles (5 ms at 10 ns).
REQ-002 SHALL have parameter OFF_TIME, default 32'd0_500_000, minimum LED-off gap between consecutive blinks in clk cycles.
REQ-003 SHALL have parameter PENDING_MAX, default 15, maximum queued events; pending width = 4 bits.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on posedge clk.
REQ-005 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-006 SHALL have port event_pulse, input, 1, single-cycle event request (e.g. a debounced click), already synchronous to clk.
REQ-007 SHALL have port led, output, 1, physical LED drive, high = lit.
REQ-008 SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-009 SHALL have port pending, output, 4, count of queued, not-yet-started blinks.
REQ-010 SHALL have port overflow, output, 1, one-cycle pulse when an event is dropped.

Function
REQ-011 SHALL implement FSM states IDLE, ON, OFF; led = 1 only in ON; registered outputs only.
REQ-012 IDLE: event_pulse=1 SHALL move to ON next cycle, with led=1 and the interval counter cleared; one cycle of latency.
REQ-013 IDLE with pending>0 SHALL never persist; pending is nonzero only while busy.
REQ-014 ON SHALL last exactly ON_TIME cycles; the counter runs 0..ON_TIME-1, then the state moves to OFF with the counter cleared.
REQ-015 OFF SHALL last exactly OFF_TIME cycles; at terminal count, pending>0 moves to ON and decrements pending, otherwise the state moves to IDLE.
REQ-016 event_pulse in ON or OFF SHALL increment pending; it SHALL NOT extend or restart the current blink.
REQ-017 Event in the same cycle as an OFF->ON consume SHALL leave pending unchanged (+1-1).
REQ-018 Event while pending==PENDING_MAX and no consume that cycle SHALL drop the event, hold pending, and pulse overflow for 1 cycle.
REQ-019 Counter SHALL be 32 bits; ON_TIME and OFF_TIME SHALL be >=1; no wrap possible since the counter clears at terminal count.
REQ-020 Each accepted event SHALL produce exactly one distinct blink; blinks SHALL never merge.

Reset
REQ-021 rst=1 SHALL force, on the next posedge: state=IDLE, counter=0, led=0, busy=0, pending=0, overflow=0.
REQ-022 rst SHALL override event_pulse in the same cycle; the event SHALL be discarded.
REQ-023 rst mid-blink (ON or OFF) SHALL abort immediately, dropping all queued events; operation resumes on the first event after rst falls.

Structure
REQ-024 Shared package led_blink_pkg SHALL hold the state typedef (IDLE/ON/OFF), PEND_W=4 and CNT_W=32 constants.
REQ-025 SHALL instantiate one sub-module led_interval_timer with inputs clk, rst, clear, enable, limit and output done, which pulses on the count == limit-1 cycle.
REQ-026 FSM, pending counter and overflow logic SHALL reside in led_blink_driver.

Verification (ON_TIME=4, OFF_TIME=3, PENDING_MAX=3)
REQ-027 Single event at cycle 10 -> led high cycles 11-14, low from 15; busy high 11-17; idle at 18.
REQ-028 Events at cycles 10, 12, 13 -> pending 1 then 2; three blinks with led high 11-14, 18-21, 25-28; 3-cycle gaps.
REQ-029 Five events back-to-back at 11-15 during a blink -> pending saturates at 3; overflow pulses once, at the 5th event; exactly 4 blinks total.
REQ-030 Event coincident with the OFF->ON consume at pending=1 -> pending stays 1; the next blink still occurs.
REQ-031 rst asserted mid-ON with pending=2 -> next cycle led=0, busy=0, pending=0; no further blinks.
REQ-032 rst and event_pulse asserted in the same cycle -> no blink; event_pulse 1 cycle after rst falls -> normal blink.
